// File: rtl/syscall_reader_pkg.sv
// ---------------------------------------------------------------------------
// syscall_pkg
//   Shared definitions for the input-side syscall service unit:
//   SPIM service codes, the ASCII bytes the parsers care about, the
//   service FSM state type and a small digit-classification helper.
// ---------------------------------------------------------------------------
package syscall_pkg;

    // SPIM service codes carried in $v0
    localparam logic [31:0] SYS_PRINT_INT = 32'd1;
    localparam logic [31:0] SYS_PRINT_STR = 32'd4;
    localparam logic [31:0] SYS_READ_INT  = 32'd5;
    localparam logic [31:0] SYS_READ_STR  = 32'd8;
    localparam logic [31:0] SYS_EXIT      = 32'd10;

    // ASCII bytes recognised by the console parsers
    localparam logic [7:0] NL    = 8'h0A;
    localparam logic [7:0] SP    = 8'h20;
    localparam logic [7:0] MINUS = 8'h2D;
    localparam logic [7:0] ZERO  = 8'h30;

    // Service FSM states.
    //   ST_STR_FLUSH : waits for any in-flight word write, then flushes the packer
    //   ST_STR_LAST  : the cycle in which the final (NUL-terminated) word is written
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INT,
        ST_INT_WB,
        ST_STR,
        ST_STR_FLUSH,
        ST_STR_LAST,
        ST_DONE
    } state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ZERO) && (b <= 8'h39);
    endfunction

endpackage

// File: rtl/syscall_reader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
//   Little-endian 4-lane word assembler. Byte k of a word lands in bits
//   [8k+7:8k]. When the fourth byte is pushed, or on flush, the assembled
//   word is registered on 'word' and 'word_ready' pulses for one cycle.
//   Unfilled lanes are always zero, so a flush naturally appends the NUL
//   and zero-pads; a flush with no pending bytes yields an all-zero word.
//
// Ports
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   clear      in   discard any partial word (start of a new string)
//   push       in   accept din into the next free lane
//   flush      in   emit the partial word (never together with push)
//   din        in   8-bit data byte
//   word       out  last completed word
//   word_ready out  one-cycle pulse, word valid
// ---------------------------------------------------------------------------
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  logic        flush,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0]  lane_cnt_reg;
    logic [31:0] pack_reg;
    logic [31:0] word_reg;
    logic        word_ready_reg;
    logic [31:0] word_next;
    logic        word_done;

    // Assembled word including a byte pushed this cycle, so the fourth
    // byte can be emitted in the same edge it is accepted.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign word_next[8*gi +: 8] =
                (push && (lane_cnt_reg == 2'(gi))) ? din : pack_reg[8*gi +: 8];
        end
    endgenerate

    assign word_done = (push && (lane_cnt_reg == 2'd3)) || flush;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lane_cnt_reg   <= 2'd0;
            pack_reg       <= 32'd0;
            word_reg       <= 32'd0;
            word_ready_reg <= 1'b0;
        end else begin
            word_ready_reg <= word_done;
            if (word_done) begin
                word_reg     <= word_next;
                pack_reg     <= 32'd0;
                lane_cnt_reg <= 2'd0;
            end else if (push) begin
                pack_reg[8*lane_cnt_reg +: 8] <= din;
                lane_cnt_reg                  <= lane_cnt_reg + 2'd1;
            end
        end
    end

    assign word       = word_reg;
    assign word_ready = word_ready_reg;

endmodule

// File: rtl/syscall_reader.sv
// ---------------------------------------------------------------------------
// syscall_reader
//   Input-side syscall service unit. Services read_int (v0=5) and
//   read_string (v0=8) from a valid/ready console byte stream while
//   stalling the pipeline. read_int writes the parsed value to $v0 through
//   wb_en/wb_data; read_string packs bytes little-endian into memory words.
//
// Ports
//   clk        in   clock
//   reset      in   synchronous active-high reset (aborts any service)
//   sys        in   one-cycle syscall pulse
//   regv       in   $v0 service code
//   rega       in   $a0 buffer byte address
//   rega1      in   $a1 buffer length in bytes
//   rx_data    in   console byte
//   rx_valid   in   console byte valid
//   rx_ready   out  byte accepted when rx_valid && rx_ready
//   stall      out  pipeline freeze while busy
//   wb_en      out  one-cycle $v0 write strobe
//   wb_data    out  read_int result
//   mem_we     out  one-cycle word write strobe
//   mem_addr   out  word address
//   mem_wdata  out  packed word
//   done       out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module syscall_reader
    import syscall_pkg::*;
#(
    parameter int MAX_STR = 256,
    parameter int ADDR_W  = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sys,
    input  logic [31:0]       regv,
    input  logic [31:0]       rega,
    input  logic [31:0]       rega1,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              stall,
    output logic              wb_en,
    output logic [31:0]       wb_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done
);

    localparam int CNT_W = $clog2(MAX_STR + 1);

    state_t              state_reg;
    logic                stall_reg;
    logic                done_reg;
    logic                wb_en_reg;
    logic [31:0]         wb_data_reg;
    logic                rx_en_reg;
    logic [31:0]         acc_reg;
    logic                neg_reg;
    logic                started_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [CNT_W-1:0]    limit_reg;

    logic [CNT_W-1:0]    limit_next;
    logic [CNT_W-1:0]    cnt_next;
    logic                rx_fire;
    logic                pk_push;
    logic                pk_flush;
    logic                pk_clear;
    logic                pk_ready;
    logic [31:0]         pk_word;
    logic                unused_bits;

    // Buffer byte address low bits are ignored: writes are word-aligned.
    assign unused_bits = ^rega[1:0];

    // Acceptance is suppressed while a word write is in flight so the
    // packer never has to hold two words at once.
    assign rx_ready = rx_en_reg && !pk_ready;
    assign rx_fire  = rx_valid && rx_ready;

    assign limit_next = (rega1 > 32'(MAX_STR)) ? CNT_W'(MAX_STR) : CNT_W'(rega1);
    assign cnt_next   = cnt_reg + CNT_W'(1);

    assign pk_clear = (state_reg == ST_IDLE) && sys && (regv == SYS_READ_STR);
    assign pk_push  = rx_fire && (state_reg == ST_STR);
    assign pk_flush = (state_reg == ST_STR_FLUSH) && !pk_ready;

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear),
        .push       (pk_push),
        .flush      (pk_flush),
        .din        (rx_data),
        .word       (pk_word),
        .word_ready (pk_ready)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            stall_reg   <= 1'b0;
            done_reg    <= 1'b0;
            wb_en_reg   <= 1'b0;
            wb_data_reg <= 32'd0;
            rx_en_reg   <= 1'b0;
            acc_reg     <= 32'd0;
            neg_reg     <= 1'b0;
            started_reg <= 1'b0;
            addr_reg    <= '0;
            cnt_reg     <= '0;
            limit_reg   <= '0;
        end else begin
            done_reg  <= 1'b0;
            wb_en_reg <= 1'b0;

            // Each word write consumes the current address.
            if (pk_ready) begin
                addr_reg <= addr_reg + ADDR_W'(1);
            end

            case (state_reg)
                ST_IDLE: begin
                    if (sys && (regv == SYS_READ_INT)) begin
                        state_reg   <= ST_INT;
                        stall_reg   <= 1'b1;
                        rx_en_reg   <= 1'b1;
                        acc_reg     <= 32'd0;
                        neg_reg     <= 1'b0;
                        started_reg <= 1'b0;
                    end else if (sys && (regv == SYS_READ_STR)) begin
                        stall_reg <= 1'b1;
                        addr_reg  <= ADDR_W'(rega[31:2]);
                        cnt_reg   <= '0;
                        limit_reg <= limit_next;
                        if (limit_next == '0) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else if (limit_next == CNT_W'(1)) begin
                            // Room for the NUL only.
                            state_reg <= ST_STR_FLUSH;
                        end else begin
                            state_reg <= ST_STR;
                            rx_en_reg <= 1'b1;
                        end
                    end
                end

                ST_INT: begin
                    if (rx_fire) begin
                        if (rx_data == NL) begin
                            rx_en_reg   <= 1'b0;
                            wb_en_reg   <= 1'b1;
                            wb_data_reg <= neg_reg ? (32'd0 - acc_reg) : acc_reg;
                            state_reg   <= ST_INT_WB;
                        end else if ((rx_data == SP) && !started_reg) begin
                            // leading blank: skip
                        end else if ((rx_data == MINUS) && !started_reg) begin
                            neg_reg     <= 1'b1;
                            started_reg <= 1'b1;
                        end else if (is_digit(rx_data)) begin
                            // acc*10 + d, wrapping modulo 2^32
                            acc_reg     <= (acc_reg << 3) + (acc_reg << 1)
                                           + 32'(rx_data[3:0]);
                            started_reg <= 1'b1;
                        end else begin
                            started_reg <= 1'b1;
                        end
                    end
                end

                ST_INT_WB: begin
                    state_reg <= ST_DONE;
                    done_reg  <= 1'b1;
                end

                ST_STR: begin
                    if (rx_fire) begin
                        cnt_reg <= cnt_next;
                        // One slot is always reserved for the NUL.
                        if ((rx_data == NL) || (cnt_next == limit_reg - CNT_W'(1))) begin
                            rx_en_reg <= 1'b0;
                            state_reg <= ST_STR_FLUSH;
                        end
                    end
                end

                ST_STR_FLUSH: begin
                    if (!pk_ready) begin
                        state_reg <= ST_STR_LAST;
                    end
                end

                ST_STR_LAST: begin
                    state_reg <= ST_DONE;
                    done_reg  <= 1'b1;
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    stall_reg <= 1'b0;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    stall_reg <= 1'b0;
                    rx_en_reg <= 1'b0;
                end
            endcase
        end
    end

    assign stall     = stall_reg;
    assign done      = done_reg;
    assign wb_en     = wb_en_reg;
    assign wb_data   = wb_data_reg;
    assign mem_we    = pk_ready;
    assign mem_addr  = addr_reg;
    assign mem_wdata = pk_word;

endmodule

// File: tb/tb_syscall_reader.sv
// ---------------------------------------------------------------------------
// tb_syscall_reader
//   Directed bench for syscall_reader. Expected $v0 writes and memory word
//   writes are queued when a service is started and checked in order by a
//   monitor as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_syscall_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        sys;
    logic [31:0] regv;
    logic [31:0] rega;
    logic [31:0] rega1;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        stall;
    logic        wb_en;
    logic [31:0] wb_data;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        done;

    syscall_reader #(.MAX_STR(256), .ADDR_W(30)) dut (
        .clk       (clk),
        .reset     (reset),
        .sys       (sys),
        .regv      (regv),
        .rega      (rega),
        .rega1     (rega1),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .stall     (stall),
        .wb_en     (wb_en),
        .wb_data   (wb_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_mem;
        logic [29:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic exp_mem(input logic [29:0] a, input logic [31:0] d);
        exp_t e;
        e.is_mem = 1'b1; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    task automatic exp_wb(input logic [31:0] d);
        exp_t e;
        e.is_mem = 1'b0; e.addr = '0; e.data = d;
        sb.push_back(e);
    endtask

    // Output monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (wb_en || mem_we) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {30'd0, wb_en, mem_we}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("write_kind", {31'd0, mem_we}, {31'd0, e.is_mem});
                if (mem_we) begin
                    $display("txn mem_write addr=%h data=%h", mem_addr, mem_wdata);
                    check("mem_addr", {2'b0, mem_addr}, {2'b0, e.addr});
                    check("mem_wdata", mem_wdata, e.data);
                    check("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
                end else begin
                    $display("txn wb_write data=%h", wb_data);
                    check("wb_data", wb_data, e.data);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] v, input logic [31:0] a, input logic [31:0] l);
        sys = 1'b1; regv = v; rega = a; rega1 = l;
        tick();
        sys = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // Wait for done with stall held high; optionally require rx_ready low
    // throughout (a byte is being offered that must not be consumed).
    task automatic wait_done(input string tag, input bit hold_check);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check({tag, "_stall_busy"}, {31'd0, stall}, 32'd1);
            if (hold_check) check({tag, "_no_accept"}, {31'd0, rx_ready}, 32'd0);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        @(negedge clk);
        check({tag, "_stall_drop"}, {31'd0, stall}, 32'd0);
        check({tag, "_done_single"}, {31'd0, done}, 32'd0);
        check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"},     {31'd0, stall},    32'd0);
        check({tag, "_done"},      {31'd0, done},     32'd0);
        check({tag, "_wb_en"},     {31'd0, wb_en},    32'd0);
        check({tag, "_mem_we"},    {31'd0, mem_we},   32'd0);
        check({tag, "_rx_ready"},  {31'd0, rx_ready}, 32'd0);
        check({tag, "_wb_data"},   wb_data,           32'd0);
        check({tag, "_mem_addr"},  {2'b0, mem_addr},  32'd0);
        check({tag, "_mem_wdata"}, mem_wdata,         32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; sys = 1'b0; regv = '0; rega = '0; rega1 = '0;
        rx_data = '0; rx_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        reset = 1'b0;
        tick();

        // read_int with leading blank and sign
        exp_wb(32'hFFFFFF85);
        start(32'd5, '0, '0);
        @(negedge clk);
        check("int_stall_start", {31'd0, stall}, 32'd1);
        tick();
        send_str(" -123\n");
        wait_done("int_neg", 1'b0);

        // read_int wraps modulo 2^32
        exp_wb(32'd1);
        start(32'd5, '0, '0);
        send_str("4294967297\n");
        wait_done("int_ovf", 1'b0);

        // newline with no digits yields 0
        exp_wb(32'd0);
        start(32'd5, '0, '0);
        send_str("\n");
        wait_done("int_empty", 1'b0);

        // read_string exact fill: 7 data bytes + NUL, 'h' left unconsumed
        exp_mem(30'h100004, 32'h64636261);
        exp_mem(30'h100005, 32'h00676665);
        start(32'd8, 32'h00400010, 32'd8);
        send_str("abcdefg");
        rx_data = "h"; rx_valid = 1'b1;
        wait_done("str_fill", 1'b1);
        rx_valid = 1'b0;

        // newline terminates, stored before NUL
        exp_mem(30'h000400, 32'h000A6968);
        start(32'd8, 32'h00001000, 32'd64);
        send_str("hi\n");
        wait_done("str_nl", 1'b0);

        // 4-byte input fills a word; NUL goes into a fresh zero word
        exp_mem(30'h000800, 32'h0A636261);
        exp_mem(30'h000801, 32'h00000000);
        start(32'd8, 32'h00002000, 32'd64);
        send_str("abc\n");
        wait_done("str_full_word", 1'b0);

        // zero-length buffer: no write
        start(32'd8, 32'h00003000, 32'd0);
        wait_done("str_len0", 1'b0);

        // one-byte buffer: only the NUL word, low address bits ignored
        exp_mem(30'h000400, 32'h00000000);
        start(32'd8, 32'h00001003, 32'd1);
        wait_done("str_len1", 1'b0);

        // unsupported code: no stall, no done
        start(32'd3, '0, '0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("other_code_stall", {31'd0, stall}, 32'd0);
            check("other_code_done",  {31'd0, done},  32'd0);
        end
        tick();

        // sys while busy is ignored
        exp_wb(32'd9);
        start(32'd5, '0, '0);
        start(32'd8, 32'h00005000, 32'd4);
        send_str("9\n");
        wait_done("busy_sys", 1'b0);

        // reset in the middle of a read_string
        exp_mem(30'h000080, 32'h64636261);
        start(32'd8, 32'h00000200, 32'd64);
        send_str("abcde");
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        repeat (4) tick();
        check("midreset_sb_drained", 32'(sb.size()), 32'd0);
        check("midreset_idle_stall", {31'd0, stall}, 32'd0);

        // fresh service after the abort
        exp_wb(32'd42);
        start(32'd5, '0, '0);
        send_str("42\n");
        wait_done("post_reset_int", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/syscall_reader.md
Name: syscall_reader

Overview:
- Input-side syscall service unit; counterpart to the existing print-int/print-string/exit handling in the instruction/data memory block.
- Services SPIM read_int (v0=5) and read_string (v0=8) from an external console byte stream (valid/ready).
- read_int returns the parsed value through a register-file write port; read_string packs bytes into memory words.
- Sits beside the memory stage and holds the pipeline stalled until the service completes.

Parameters:
- MAX_STR, 256, hard cap on bytes accepted per read_string, including the NUL.
- ADDR_W, 30, word-address width of the memory write port.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- sys  in  1  one-cycle syscall pulse from decode/execute
- regv  in  32  $v0 service code
- rega  in  32  $a0: buffer byte address (read_string)
- rega1  in  32  $a1: buffer length in bytes (read_string)
- rx_data  in  8  console byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid && rx_ready
- stall  out  1  freezes the pipeline while busy
- wb_en  out  1  one-cycle write of wb_data to $v0 (reg 2)
- wb_data  out  32  read_int result
- mem_we  out  1  one-cycle word write
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  packed word
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE; all outputs 0; accumulator, byte counter and pack register cleared.
- Reset mid-operation aborts the service with no further writes. A partially written buffer stays as written.
- IDLE: sample sys.
  - regv==5 -> INT; regv==8 -> STR.
  - Any other code: no action, no stall.
  - sys while not IDLE is ignored.
- stall is registered. It is 1 from the cycle after the accepting sys through the cycle done is high, and drops the cycle after.
- rx_ready is 1 only in INT and STR. A byte transfers when rx_valid && rx_ready.
- INT state:
  - Leading 0x20 bytes are skipped.
  - A first non-space '-' sets neg.
  - '0'..'9': acc <= acc*10 + d, mod 2^32.
  - 0x0A terminates -> INT_WB.
  - Any other byte is ignored.
- INT_WB (1 cycle): wb_en=1, wb_data = neg ? -acc : acc (32-bit two's complement) -> DONE.
  - Newline with no digits returns 0.
- STR entry: word address = rega[31:2] (low bits ignored); limit = min(rega1, MAX_STR).
  - limit==0 -> DONE, no write.
  - limit==1 -> single write of 0x00000000 -> DONE.
- STR byte packing: little-endian. Byte k of the word goes to bits [8k+7:8k], matching the print-string unpack order.
- STR byte acceptance: accepts at most limit-1 data bytes.
  - A 0x0A byte is stored and then ends reception.
  - Reaching limit-1 bytes also ends reception.
- STR word writes: when the 4th byte of a word is packed, mem_we pulses the next cycle at the current address, then the address increments. Wrap past 2^ADDR_W-1 to 0 is permitted.
- STR_FLUSH: appends NUL, zero-pads the remaining lanes, and writes the final word.
  - If the data length is a multiple of 4, the flush writes a full zero word at the next address.
  - Exactly one write per word; no write without data or NUL in it.
- DONE (1 cycle): done=1 -> IDLE.
- While mem_we is high, rx_ready is 0. No byte is accepted in a write cycle, so a single write port suffices.

Decomposition:
- Shared package syscall_pkg:
  - service codes SYS_PRINT_INT=1, SYS_PRINT_STR=4, SYS_READ_INT=5, SYS_READ_STR=8, SYS_EXIT=10
  - ASCII constants NL=8'h0A, SP=8'h20, MINUS=8'h2D, ZERO=8'h30
  - FSM state enum
- One sub-module, byte_packer: shift-in 4-lane word assembler with lane counter, flush/zero-pad and word_ready output. The FSM lives in syscall_reader.

Test Plan:
- read_int: sys with regv=5, stream " -123\n" -> one wb_en, wb_data=32'hFFFFFF85; done one cycle later; stall high throughout.
- read_int overflow: stream "4294967297\n" -> wb_data=1.
- read_string exact fill: regv=8, rega=32'h00400010, rega1=8, stream "abcdefgh" -> words "abcd"=32'h64636261 at 0x100004, then "efg\0"=32'h00676665 at 0x100005. 'h' is not consumed (rx_ready low after the 7th byte).
- read_string newline: rega1=64, stream "hi\n" -> single write 32'h000A6968; a 4-byte input "abc\n" -> writes 32'h0A636261 then 32'h00000000.
- Edge cases:
  - rega1=0 -> no mem_we, done.
  - rega1=1 -> one write of 0.
  - regv=3 -> no stall, no done.
  - sys asserted while busy -> ignored.
- Reset mid-operation: reset asserted during STR after 5 bytes -> next cycle all outputs 0, IDLE. A fresh regv=5 service then works normally.
